// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog: per-channel enable, config load and divided-clock outputs.
// Vectors are packed per channel; channel k uses bit k, or bits [k*W +: W] for config fields.
interface clock_divider_prog_if #(
  parameter int W  = 16,
  parameter int CH = 2
);
  logic [CH-1:0]   en_i;
  logic [CH-1:0]   load_i;
  logic [CH*W-1:0] div_i;
  logic [CH*W-1:0] high_i;
  logic [CH-1:0]   clk_o;
  logic [CH-1:0]   rise_o;
  logic [CH-1:0]   fall_o;
  logic [CH-1:0]   busy_o;
  logic [CH-1:0]   err_o;

  modport master (
    output en_i, load_i, div_i, high_i,
    input  clk_o, rise_o, fall_o, busy_o, err_o
  );

  modport slave (
    input  en_i, load_i, div_i, high_i,
    output clk_o, rise_o, fall_o, busy_o, err_o
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider with rise/fall strobes; 1 cycle from en_i to clk_o high.
// No backpressure: every load is accepted (applied now or at the next wrap) or rejected via err_o.
module clock_divider_prog #(
  parameter int W        = 16,
  parameter int CH       = 2,
  parameter int DEF_DIV  = 50,
  parameter int DEF_HIGH = 25
) (
  input logic                 clk_i,
  input logic                 rst_i,
  clock_divider_prog_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [W-1:0] DEF_DIV_W  = W'(DEF_DIV);
  localparam logic [W-1:0] DEF_HIGH_W = W'(DEF_HIGH);

  genvar k;
  generate
    for (k = 0; k < CH; k++) begin : g_ch
      state_t       state;
      logic [W-1:0] cnt;
      logic [W-1:0] div_q;
      logic [W-1:0] high_q;
      logic [W-1:0] pend_div;
      logic [W-1:0] pend_high;
      logic         pend_vld;
      logic         clk_q;
      logic         rise_q;
      logic         fall_q;
      logic         busy_q;
      logic         err_q;

      logic [W-1:0] ld_div;
      logic [W-1:0] ld_high;
      logic         ld_ok;
      logic         ld_acc;
      logic         wrap;
      logic         fall_pt;

      assign ld_div  = bus.div_i[k*W +: W];
      assign ld_high = bus.high_i[k*W +: W];
      assign ld_ok   = (ld_div >= W'(2)) && (ld_high != '0) && (ld_high < ld_div);
      assign ld_acc  = bus.load_i[k] && ld_ok;
      // cnt never exceeds div_q-1, and high_q < div_q keeps fall and wrap on distinct cycles
      assign wrap    = (cnt == div_q - W'(1));
      assign fall_pt = (cnt == high_q - W'(1));

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state     <= IDLE;
          cnt       <= '0;
          div_q     <= DEF_DIV_W;
          high_q    <= DEF_HIGH_W;
          pend_div  <= '0;
          pend_high <= '0;
          pend_vld  <= 1'b0;
          clk_q     <= 1'b0;
          rise_q    <= 1'b0;
          fall_q    <= 1'b0;
          busy_q    <= 1'b0;
          err_q     <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          err_q  <= bus.load_i[k] && !ld_ok;

          case (state)
            IDLE: begin
              cnt <= '0;
              if (ld_acc) begin
                div_q    <= ld_div;
                high_q   <= ld_high;
                pend_vld <= 1'b0;
              end
              if (bus.en_i[k]) begin
                state  <= RUN;
                clk_q  <= 1'b1;
                rise_q <= 1'b1;
                busy_q <= 1'b1;
              end
            end

            default: begin
              if (wrap) begin
                cnt <= '0;
                if (pend_vld) begin
                  div_q    <= pend_div;
                  high_q   <= pend_high;
                  pend_vld <= 1'b0;
                end
                if (bus.en_i[k]) begin
                  state  <= RUN;
                  clk_q  <= 1'b1;
                  rise_q <= 1'b1;
                end else begin
                  state  <= IDLE;
                  clk_q  <= 1'b0;
                  busy_q <= 1'b0;
                end
              end else begin
                cnt   <= cnt + W'(1);
                state <= bus.en_i[k] ? RUN : STOP;
                if (fall_pt) begin
                  clk_q  <= 1'b0;
                  fall_q <= 1'b1;
                end
              end
              // A load on the wrap cycle lands after the old pending value is consumed
              if (ld_acc) begin
                pend_div  <= ld_div;
                pend_high <= ld_high;
                pend_vld  <= 1'b1;
              end
            end
          endcase
        end
      end

      assign bus.clk_o[k]  = clk_q;
      assign bus.rise_o[k] = rise_q;
      assign bus.fall_o[k] = fall_q;
      assign bus.busy_o[k] = busy_q;
      assign bus.err_o[k]  = err_q;
    end
  endgenerate

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Multi-channel, runtime-programmable clock divider. Next generation of the fixed-ratio divider.
- Each channel generates a divided clock with programmable period and high time, so odd ratios and non-50% duty are supported.
- Each channel also provides single-cycle rise/fall strobes, for use as clock-enables in the clk_i domain.
- Per-channel enable with graceful stop. Configuration updates are glitch-free and apply only at period boundaries.
- Sits between the system clock and slow peripherals (display scan, debouncers, UART baud, PWM).

Parameters:
- W, 16, counter/config width per channel (2..32).
- CH, 2, number of independent channels (1..8).
- DEF_DIV, 50, reset period in clk_i cycles (2 <= DEF_DIV < 2^W).
- DEF_HIGH, 25, reset high time in clk_i cycles (1 <= DEF_HIGH < DEF_DIV).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  CH  per-channel run enable (level).
- load_i  in  CH  per-channel config load strobe (1 cycle).
- div_i  in  CH*W  period for channel k at bits [k*W +: W].
- high_i  in  CH*W  high time for channel k at bits [k*W +: W].
- clk_o  out  CH  divided clock per channel (registered).
- rise_o  out  CH  1-cycle strobe, same edge clk_o goes 0->1.
- fall_o  out  CH  1-cycle strobe, same edge clk_o goes 1->0.
- busy_o  out  CH  channel running (RUN or STOP state).
- err_o  out  CH  1-cycle strobe: illegal config rejected.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- All outputs are registered. Channels are fully independent; the description below is per channel.

Reset:
- clk_o=0, rise_o=0, fall_o=0, busy_o=0, err_o=0.
- State=IDLE, cnt=0.
- Active config: div_q=DEF_DIV, high_q=DEF_HIGH.
- No pending config.
- Reset asserted mid-period returns to this state immediately and drops clk_o with no fall_o strobe.

Config load:
- On load_i=1, div_i/high_i are checked.
- Legal config: div>=2 and 1<=high<div.
- Illegal config: err_o=1 on the next cycle, and both active and pending config stay unchanged.
- Legal config in IDLE: written to div_q/high_q directly.
- Legal config in RUN/STOP: stored as pending, overwriting any earlier pending value (last load wins).
- Pending config is copied to div_q/high_q at the next wrap edge.
- A load on the same cycle as a wrap applies at the following wrap.

States:
- IDLE: cnt=0, clk_o=0, busy_o=0.
  - en_i=1 -> RUN. Next edge: cnt=0, clk_o=1, rise_o=1, busy_o=1.
  - Latency from en_i high to clk_o high is 1 cycle.
- RUN: cnt increments each cycle.
  - cnt==high_q-1 -> next edge clk_o=0, fall_o=1.
  - cnt==div_q-1 (wrap) -> next edge cnt=0, clk_o=1, rise_o=1, pending config applied.
  - en_i=0 seen in RUN -> STOP.
- STOP: counting continues as in RUN.
  - High and low phases complete normally.
  - At wrap: go to IDLE with clk_o=0, no rise_o, busy_o=0, and pending config applied.
  - en_i=1 seen in STOP -> back to RUN with no disturbance.
- Glitch rule: no high or low phase is ever truncated, except by reset.

Timing and arithmetic:
- clk_o is high for exactly high_q cycles and low for div_q-high_q cycles.
- Period is exactly div_q cycles.
- With div_q=2, high_q=1: clk_o toggles every cycle; rise_o and fall_o alternate.
- cnt is W bits and never exceeds div_q-1, so no overflow is possible.
- Comparisons are unsigned.
- rise_o and fall_o are never both high in the same cycle.

Test Plan:
- Reset, en_i[0]=1, defaults: clk_o[0] high 25 cycles, low 25 cycles, period 50. rise_o[0] every 50 cycles. busy_o[0]=1 after 1 cycle.
- In IDLE, load div=7, high=3, then enable: pattern 3 high / 4 low repeating. fall_o 3 cycles after rise_o.
- While running div=7/high=3, load div=4/high=1 mid-period: current 7-cycle period completes unchanged, then 1 high / 3 low from the next rise_o.
- Load div=5/high=5, then div=1/high=0: err_o pulses once per load, and the 7/3 pattern continues unchanged.
- Drop en_i during the high phase: high and low phases finish, then clk_o=0, busy_o=0, no further rise_o. Re-raise en_i during STOP: no gap in the pattern.
- Two channels with div 2/1 and 3/2, and rst_i asserted mid-period: outputs independent before reset; all outputs 0 asynchronously; defaults restored after reset.
